// File: rtl/btn_debounce.sv
// btn_debounce: debounces one push-button against the 1 us tick and produces a clean level
// plus one-clk press/release pulses. Define LONG_PRESS_EN to add the one-shot btn_long pulse.
module btn_debounce #(
    parameter int STABLE_US  = 5000,
    parameter int CNT_W      = 13,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int LONG_US    = 1000000,
    parameter int LONG_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic every_us,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    // state        | meaning
    // RELEASED     | accepted level is released, input agrees
    // PRESS_WAIT   | input reads pressed, counting stable ticks
    // PRESSED      | accepted level is pressed, input agrees
    // RELEASE_WAIT | input reads released, counting stable ticks
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic             IDLE_LVL = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_US - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sync_a, sync_b, p;
    logic             press_nxt, release_nxt, level_nxt;

    // Synchroniser resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= IDLE_LVL;
            sync_b <= IDLE_LVL;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    assign p = ACTIVE_LOW ? ~sync_b : sync_b;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (p) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                // A revert outranks a coincident tick: that tick is not counted.
                if (!p) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (every_us) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (p) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (every_us) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt   = RELEASED;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RELEASED;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

`ifdef LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_US);

    logic [LONG_W-1:0] lcnt, lcnt_nxt;
    logic              long_nxt;

    // Hold time survives a release bounce; it restarts only on a fresh accepted press.
    always_comb begin
        lcnt_nxt = lcnt;
        long_nxt = 1'b0;
        if (state_nxt == RELEASED) begin
            lcnt_nxt = '0;
        end else if ((state == PRESS_WAIT) && (state_nxt == PRESSED)) begin
            lcnt_nxt = '0;
        end else if (((state == PRESSED) || (state == RELEASE_WAIT)) && every_us
                     && (lcnt != LONG_LAST)) begin
            lcnt_nxt = lcnt + 1'b1;
            long_nxt = (lcnt_nxt == LONG_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcnt     <= '0;
            btn_long <= 1'b0;
        end else begin
            lcnt     <= lcnt_nxt;
            btn_long <= long_nxt;
        end
    end
`else
    assign btn_long = 1'b0;
`endif

endmodule
